// File: rtl/app_state_pkg.sv
// Shared state codes, menu geometry and the menu-item-to-application map
// used by the application sequencer.
package app_state_pkg;

    localparam logic [3:0] ST_MENU         = 4'd0;
    localparam logic [3:0] ST_VOLUME       = 4'd1;
    localparam logic [3:0] ST_POKEMON      = 4'd2;
    localparam logic [3:0] ST_POKEMON_OVER = 4'd3;
    localparam logic [3:0] ST_BLUE         = 4'd4;
    localparam logic [3:0] ST_POTION       = 4'd5;
    localparam logic [3:0] ST_YELLOW       = 4'd6;

    localparam int         NUM_MENU_ITEMS  = 5;
    localparam logic [2:0] CURSOR_LAST     = 3'(NUM_MENU_ITEMS - 1);

    // One-cycle press pulses from the four debounced buttons.
    typedef struct packed {
        logic up;
        logic down;
        logic center;
        logic left;
    } btn_press_t;

    function automatic logic [3:0] item_to_state(input logic [2:0] item);
        logic [3:0] st;
        case (item)
            3'd0:    st = ST_VOLUME;
            3'd1:    st = ST_POKEMON;
            3'd2:    st = ST_BLUE;
            3'd3:    st = ST_POTION;
            3'd4:    st = ST_YELLOW;
            default: st = ST_MENU;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises one raw push-button and accepts a new level only after it has
// been stable for DEBOUNCE_CYCLES samples; emits a one-cycle pulse on press.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 100_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press_pulse
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counts consecutive synchronised samples that disagree with the accepted
    // level; any agreeing sample restarts the count, so glitches never land.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        level_d = level_q;
        pulse_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values; reset is synchronous and wins over all else.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level       = level_q;
    assign press_pulse = pulse_q;

endmodule

// File: rtl/app_state_ctrl.sv
// Top-level application sequencer: debounced menu navigation, app launch/exit,
// Pokemon game-over timeout, and a one-cycle app_reset on every state change.
module app_state_ctrl
    import app_state_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100_000,
    parameter int GAMEOVER_CYCLES = 300_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnC,
    input  logic       btnL,
    input  logic       pokemon_dead,
    output logic [3:0] state,
    output logic [2:0] menu_cursor,
    output logic       app_reset
);

    localparam int            TW         = $clog2(GAMEOVER_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(GAMEOVER_CYCLES - 1);

    logic [3:0]    raw_vec;
    logic [3:0]    press_vec;
    logic [3:0]    btn_level_unused;
    btn_press_t    btn_press;

    logic [3:0]    state_q, state_d;
    logic [2:0]    cursor_q, cursor_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          app_reset_q, app_reset_d;

    // Bit order matches btn_press_t: up is the MSB, left the LSB.
    assign raw_vec = {btnU, btnD, btnC, btnL};

    for (genvar i = 0; i < 4; i++) begin : gen_deb
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk        (clk),
            .reset      (reset),
            .raw        (raw_vec[i]),
            .level      (btn_level_unused[i]),
            .press_pulse(press_vec[i])
        );
    end

    assign btn_press = btn_press_t'(press_vec);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_MENU;
            cursor_q    <= '0;
            timer_q     <= '0;
            app_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            timer_q     <= timer_d;
            app_reset_q <= app_reset_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        case (state_q)
            ST_MENU: begin
                if (btn_press.center) begin
                    state_d = item_to_state(cursor_q);
                end else if (btn_press.up && !btn_press.down) begin
                    cursor_d = (cursor_q == '0) ? CURSOR_LAST : cursor_q - 1'b1;
                end else if (btn_press.down && !btn_press.up) begin
                    cursor_d = (cursor_q == CURSOR_LAST) ? '0 : cursor_q + 1'b1;
                end
            end
            ST_VOLUME, ST_BLUE, ST_POTION, ST_YELLOW: begin
                if (btn_press.left) state_d = ST_MENU;
            end
            ST_POKEMON: begin
                if (pokemon_dead)        state_d = ST_POKEMON_OVER;
                else if (btn_press.left) state_d = ST_MENU;
            end
            ST_POKEMON_OVER: begin
                if (btn_press.center || btn_press.left || timer_q == TIMER_LAST)
                    state_d = ST_MENU;
            end
            default: state_d = ST_MENU;
        endcase

        // The timer only runs while staying in POKEMON_OVER, so every entry starts at 0.
        timer_d     = (state_q == ST_POKEMON_OVER && state_d == ST_POKEMON_OVER)
                      ? timer_q + 1'b1 : '0;
        app_reset_d = (state_d != state_q);
    end

    always_comb begin
        state       = state_q;
        menu_cursor = cursor_q;
        app_reset   = app_reset_q;
    end

endmodule

// File: tb/tb_app_state_ctrl.sv
// Directed and randomized bench for app_state_ctrl, checked every cycle against
// a history-window debounce model and a table-driven menu/app model.
module tb_app_state_ctrl;

    localparam int DB = 4;
    localparam int GO = 10;

    logic       clk;
    logic       rst_r;
    logic [3:0] btn_raw;         // [0]=U [1]=D [2]=C [3]=L
    logic       dead_r;
    logic [3:0] state;
    logic [2:0] menu_cursor;
    logic       app_reset;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_st, m_cur, m_tmr;
    bit          m_ar;
    bit          m_lvl [4];
    bit          m_pul [4];
    logic [15:0] m_hist [4];
    int          item_state [5] = '{1, 2, 4, 5, 6};

    app_state_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .GAMEOVER_CYCLES(GO)
    ) dut (
        .clk         (clk),
        .reset       (rst_r),
        .btnU        (btn_raw[0]),
        .btnD        (btn_raw[1]),
        .btnC        (btn_raw[2]),
        .btnL        (btn_raw[3]),
        .pokemon_dead(dead_r),
        .state       (state),
        .menu_cursor (menu_cursor),
        .app_reset   (app_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advances the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        int nst, ncur;
        bit u, d, c, l;
        logic [DB-1:0] win;
        if (rst_r) begin
            m_st = 0; m_cur = 0; m_tmr = 0; m_ar = 0;
            for (int b = 0; b < 4; b++) begin
                m_lvl[b] = 0; m_pul[b] = 0; m_hist[b] = '0;
            end
            return;
        end
        u = m_pul[0]; d = m_pul[1]; c = m_pul[2]; l = m_pul[3];
        nst = m_st; ncur = m_cur;
        if (m_st == 0) begin
            if (c)            nst  = item_state[m_cur];
            else if (u && !d) ncur = (m_cur + 4) % 5;
            else if (d && !u) ncur = (m_cur + 1) % 5;
        end else if (m_st == 1 || m_st == 4 || m_st == 5 || m_st == 6) begin
            if (l) nst = 0;
        end else if (m_st == 2) begin
            if (dead_r) nst = 3;
            else if (l) nst = 0;
        end else if (m_st == 3) begin
            if (c || l || m_tmr == GO - 1) nst = 0;
        end else begin
            nst = 0;
        end
        m_tmr = (m_st == 3 && nst == 3) ? m_tmr + 1 : 0;
        m_ar  = (nst != m_st);
        m_st  = nst;
        m_cur = ncur;

        // Raw value seen at this edge enters bit 0; two synchroniser stages
        // mean the debounce window is bits DB+1..2.
        for (int b = 0; b < 4; b++) begin
            m_hist[b] = {m_hist[b][14:0], btn_raw[b]};
            win = m_hist[b][DB+1:2];
            m_pul[b] = 0;
            if (!m_lvl[b] && win == {DB{1'b1}}) begin
                m_lvl[b] = 1; m_pul[b] = 1;
            end else if (m_lvl[b] && win == '0) begin
                m_lvl[b] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("state",     32'(state),          32'(m_st));
        check("cursor",    32'(menu_cursor),    32'(m_cur));
        check("app_reset", 32'(app_reset),      32'(m_ar));
        check("timer",     32'(dut.timer_q),    32'(m_tmr));
        check("pulses",    32'(dut.btn_press),
              32'({m_pul[0], m_pul[1], m_pul[2], m_pul[3]}));
    endtask

    task automatic press(input int b, output int ar_seen);
        ar_seen = 0;
        btn_raw[b] = 1'b1;
        repeat (8) begin tick(); if (app_reset === 1'b1) ar_seen++; end
        btn_raw[b] = 1'b0;
        repeat (8) begin tick(); if (app_reset === 1'b1) ar_seen++; end
    endtask

    initial begin
        int ar_cnt;
        bit got;

        // 1: reset held with buttons toggling
        rst_r = 1'b1; dead_r = 1'b0; btn_raw = '0;
        repeat (3) begin
            btn_raw = 4'($urandom);
            tick();
            check("t1_state",  32'(state),         32'd0);
            check("t1_cursor", 32'(menu_cursor),   32'd0);
            check("t1_ar",     32'(app_reset),     32'd0);
            check("t1_pulses", 32'(dut.btn_press), 32'd0);
        end
        rst_r = 1'b0; btn_raw = '0;
        repeat (2) tick();

        // 2: short glitch ignored, long hold gives exactly one step
        btn_raw[1] = 1'b1;
        repeat (2) tick();
        btn_raw[1] = 1'b0;
        repeat (10) tick();
        check("t2_glitch_cursor", 32'(menu_cursor), 32'd0);
        btn_raw[1] = 1'b1;
        repeat (20) tick();
        btn_raw[1] = 1'b0;
        repeat (8) tick();
        check("t2_hold_cursor", 32'(menu_cursor), 32'd1);

        // 3: wrap up, launch YELLOW, exit keeps cursor
        press(0, ar_cnt);
        check("t3_cursor0", 32'(menu_cursor), 32'd0);
        press(0, ar_cnt);
        check("t3_wrap_cursor", 32'(menu_cursor), 32'd4);
        check("t3_wrap_no_ar",  32'(ar_cnt),      32'd0);
        press(2, ar_cnt);
        check("t3_state_yellow", 32'(state),  32'd6);
        check("t3_ar_once",      32'(ar_cnt), 32'd1);
        press(3, ar_cnt);
        check("t3_exit_state",  32'(state),       32'd0);
        check("t3_exit_cursor", 32'(menu_cursor), 32'd4);

        // 4: dead beats L in the same cycle, then timeout back to MENU
        press(1, ar_cnt);
        press(1, ar_cnt);
        check("t4_cursor1", 32'(menu_cursor), 32'd1);
        press(2, ar_cnt);
        check("t4_pokemon", 32'(state), 32'd2);
        btn_raw[3] = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (dut.btn_press.left === 1'b1) got = 1;
        end
        check("t4_l_pulse_seen", 32'(got), 32'd1);
        dead_r = 1'b1; btn_raw[3] = 1'b0;
        tick();
        dead_r = 1'b0;
        check("t4_over", 32'(state), 32'd3);
        repeat (GO - 1) tick();
        check("t4_still_over", 32'(state), 32'd3);
        tick();
        check("t4_timeout_state", 32'(state),     32'd0);
        check("t4_timeout_ar",    32'(app_reset), 32'd1);
        repeat (8) tick();

        // 5: C pulse at timer=5 exits; re-entry restarts the timer
        press(2, ar_cnt);
        check("t5_pokemon", 32'(state), 32'd2);
        btn_raw[2] = 1'b1; dead_r = 1'b1;
        tick();
        dead_r = 1'b0;
        check("t5_over",   32'(state),       32'd3);
        check("t5_timer0", 32'(dut.timer_q), 32'd0);
        repeat (5) tick();
        check("t5_timer5",  32'(dut.timer_q),        32'd5);
        check("t5_c_pulse", 32'(dut.btn_press.center), 32'd1);
        tick();
        check("t5_exit", 32'(state), 32'd0);
        btn_raw[2] = 1'b0;
        repeat (8) tick();
        press(2, ar_cnt);
        dead_r = 1'b1;
        tick();
        dead_r = 1'b0;
        check("t5_reenter_timer0", 32'(dut.timer_q), 32'd0);
        tick();
        check("t5_reenter_timer1", 32'(dut.timer_q), 32'd1);
        press(3, ar_cnt);
        check("t5_back_menu", 32'(state), 32'd0);

        // 6: illegal code recovers; reset during POTION
        force dut.state_q = 4'd9;
        m_st = 9;
        #1;
        release dut.state_q;
        tick();
        check("t6_illegal_state", 32'(state),     32'd0);
        check("t6_illegal_ar",    32'(app_reset), 32'd1);
        press(1, ar_cnt);
        press(1, ar_cnt);
        press(2, ar_cnt);
        check("t6_potion", 32'(state), 32'd5);
        rst_r = 1'b1;
        tick();
        rst_r = 1'b0;
        check("t6_rst_state",  32'(state),       32'd0);
        check("t6_rst_cursor", 32'(menu_cursor), 32'd0);
        check("t6_rst_ar",     32'(app_reset),   32'd0);

        // Randomized phase: bouncy buttons, stray dead pulses, rare resets
        repeat (3000) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(5) == 0) btn_raw[b] = ~btn_raw[b];
            dead_r = ($urandom_range(15) == 0);
            rst_r  = ($urandom_range(699) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
